// File: rtl/serial_responder.sv
// Responder end of the 3-wire serial link: command decode plus burst read/write of a register bank.
// Optional macro SERIAL_RESPONDER_AUTOINC_EN: advance the address after every data word.
module serial_responder #(
    parameter int   BITS                 = 8,
    parameter int   NUM_REGS             = 16,
    parameter logic LOWBIT_FIRST         = 1'b1,
    parameter logic SERIAL_DATA_INACTIVE = 1'b1,
    parameter logic SELECT_ACTIVE        = 1'b1
) (
    input  logic                         serial_clk,
    input  logic                         in_rst,
    input  logic                         in_select,
    input  logic                         in_serial,
    output logic                         out_serial,
    output logic [NUM_REGS*BITS-1:0]     out_regs,
    output logic                         out_wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0]  out_wr_addr,
    output logic                         out_busy
);

    localparam int CW  = $clog2(BITS) + 1;
    localparam int IW  = $clog2(BITS);
    localparam int AW  = BITS - 1;
    localparam int WAW = $clog2(NUM_REGS);

    localparam logic [CW-1:0] CNT_LAST   = CW'(BITS - 1);
    localparam logic [AW:0]   NUM_REGS_X = (AW + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [BITS-1:0]  r_rx;
    logic [BITS-1:0]  r_tx;
    logic [AW-1:0]    r_addr;
    logic [BITS-1:0]  r_bank [NUM_REGS];
    logic             r_wr_strobe;
    logic [WAW-1:0]   r_wr_addr;
    logic             r_busy;
    logic             r_out;

    logic [IW-1:0]    w_idx;
    logic [BITS-1:0]  w_rx_next;
    logic             w_sel;
    logic             w_last;
    logic [AW-1:0]    w_cmd_addr;
    logic [AW-1:0]    w_addr_next;
    logic [BITS-1:0]  w_cmd_rd;
    logic [BITS-1:0]  w_next_rd;

    function automatic logic [IW-1:0] wire_idx(input logic [IW-1:0] cnt);
        if (LOWBIT_FIRST) begin
            return cnt;
        end else begin
            return IW'(BITS - 1) - cnt;
        end
    endfunction

    function automatic logic addr_in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < NUM_REGS_X);
    endfunction

    // Out-of-range addresses never wrap back into the bank.
    function automatic logic [AW-1:0] addr_advance(input logic [AW-1:0] a);
`ifdef SERIAL_RESPONDER_AUTOINC_EN
        if (!addr_in_range(a)) begin
            return a;
        end else if (a == AW'(NUM_REGS - 1)) begin
            return {AW{1'b0}};
        end else begin
            return a + AW'(1);
        end
`else
        return a;
`endif
    endfunction

    // Next receive word, decoded command address and bank read ports.
    always_comb begin
        w_sel       = (in_select == SELECT_ACTIVE);
        w_last      = (r_cnt == CNT_LAST);
        w_idx       = wire_idx(r_cnt[IW-1:0]);
        w_rx_next   = r_rx;
        w_rx_next[w_idx] = in_serial;
        w_cmd_addr  = w_rx_next[BITS-2:0];
        w_addr_next = addr_advance(r_addr);
        if (addr_in_range(w_cmd_addr)) begin
            w_cmd_rd = r_bank[w_cmd_addr[WAW-1:0]];
        end else begin
            w_cmd_rd = {BITS{1'b0}};
        end
        if (addr_in_range(w_addr_next)) begin
            w_next_rd = r_bank[w_addr_next[WAW-1:0]];
        end else begin
            w_next_rd = {BITS{1'b0}};
        end
    end

    // Rising-edge state machine: sampling, counters, address and bank writes.
    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_rx        <= {BITS{1'b0}};
            r_tx        <= {BITS{1'b0}};
            r_addr      <= {AW{1'b0}};
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= {WAW{1'b0}};
            r_busy      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_bank[i] <= {BITS{1'b0}};
            end
        end else begin
            r_wr_strobe <= 1'b0;
            if (!w_sel) begin
                // Deselect drops any partial word without touching the bank.
                r_state <= ST_IDLE;
                r_cnt   <= {CW{1'b0}};
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_rx    <= w_rx_next;
                        r_cnt   <= CW'(1);
                        r_state <= ST_CMD;
                        r_busy  <= 1'b1;
                    end
                    ST_CMD: begin
                        r_rx <= w_rx_next;
                        if (w_last) begin
                            r_cnt  <= {CW{1'b0}};
                            r_addr <= w_cmd_addr;
                            if (w_rx_next[BITS-1]) begin
                                r_state <= ST_READ;
                                r_tx    <= w_cmd_rd;
                            end else begin
                                r_state <= ST_WRITE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    ST_WRITE: begin
                        r_rx <= w_rx_next;
                        if (w_last) begin
                            r_cnt  <= {CW{1'b0}};
                            r_addr <= w_addr_next;
                            if (addr_in_range(r_addr)) begin
                                r_bank[r_addr[WAW-1:0]] <= w_rx_next;
                                r_wr_addr   <= r_addr[WAW-1:0];
                                r_wr_strobe <= 1'b1;
                            end else begin
                                r_wr_strobe <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    ST_READ: begin
                        if (w_last) begin
                            r_cnt  <= {CW{1'b0}};
                            r_addr <= w_addr_next;
                            r_tx   <= w_next_rd;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= {CW{1'b0}};
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Falling-edge launch so each read bit is stable at the initiator's sampling edge.
    always_ff @(negedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            r_out <= SERIAL_DATA_INACTIVE;
        end else if (r_state == ST_READ) begin
            r_out <= r_tx[w_idx];
        end else begin
            r_out <= SERIAL_DATA_INACTIVE;
        end
    end

    // Flatten the bank onto the output bus.
    always_comb begin
        out_regs = {(NUM_REGS * BITS){1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            out_regs[i*BITS +: BITS] = r_bank[i];
        end
    end

    assign out_serial    = r_out;
    assign out_wr_strobe = r_wr_strobe;
    assign out_wr_addr   = r_wr_addr;
    assign out_busy      = r_busy;

endmodule
